// File: rtl/sort_stream_ctrl.sv
// Reader-side stream controller for an external sort_node chain: loads a frame in push mode,
// then drains the chain in pop mode onto a registered valid/ready output.
module sort_stream_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_last_i,
    output logic                  arr_clk_en_o,
    output logic                  arr_push_o,
    output logic [DATA_WIDTH-1:0] arr_data_o,
    input  logic [DATA_WIDTH-1:0] arr_head_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    output logic                  busy_o
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      rem_q, rem_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        in_ready_o   = 1'b0;
        arr_clk_en_o = 1'b0;
        arr_push_o   = 1'b1;
        case (state_q)
            S_LOAD: begin
                in_ready_o = (cnt_q < DEPTH_C);
                if (in_valid_i && in_ready_o) begin
                    arr_clk_en_o = 1'b1;
                    cnt_d        = cnt_q + ONE_C;
                    // A full chain closes the frame even without in_last_i.
                    if (in_last_i || (cnt_q == DEPTH_C - ONE_C)) begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                rem_d   = cnt_q;
                cnt_d   = '0;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                arr_push_o = 1'b0;
                if ((rem_q != '0) && (!out_valid_q || out_ready_i)) begin
                    arr_clk_en_o = 1'b1;
                    out_data_d   = arr_head_i;
                    out_valid_d  = 1'b1;
                    out_last_d   = (rem_q == ONE_C);
                    rem_d        = rem_q - ONE_C;
                end else if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    if (out_valid_q && out_last_q) begin
                        out_last_d = 1'b0;
                        state_d    = S_LOAD;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
        // The chain must not step while it is being reset.
        if (rst_i) begin
            arr_clk_en_o = 1'b0;
            arr_push_o   = 1'b1;
        end
    end

    assign arr_data_o  = in_data_i;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = (state_q != S_LOAD) || (cnt_q != '0);

endmodule

// File: tb/tb_sort_stream_ctrl.sv
// Scoreboard bench for sort_stream_ctrl with a behavioural ascending sort chain attached.
module tb_sort_stream_ctrl;
    localparam int DW = 16;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          arr_clk_en;
    logic          arr_push;
    logic [DW-1:0] arr_data;
    logic [DW-1:0] arr_head;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    always #5 clk = ~clk;

    sort_stream_ctrl #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
        .arr_clk_en_o(arr_clk_en), .arr_push_o(arr_push), .arr_data_o(arr_data),
        .arr_head_i(arr_head),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_last_o(out_last), .busy_o(busy)
    );

    // Behavioural chain: push inserts in ascending order, pop shifts toward the head.
    logic [DW-1:0] ch [DP];
    int            ch_n = 0;
    always @(posedge clk) begin
        logic [DW-1:0] tmp [DP];
        logic [DW-1:0] t;
        tmp = ch;
        if (rst) begin
            for (int i = 0; i < DP; i++) tmp[i] = '1;
            ch   <= tmp;
            ch_n <= 0;
        end else if (arr_clk_en) begin
            if (arr_push) begin
                if (ch_n < DP) begin
                    tmp[ch_n] = arr_data;
                    for (int j = ch_n; j > 0; j--) begin
                        if (tmp[j] < tmp[j-1]) begin
                            t = tmp[j]; tmp[j] = tmp[j-1]; tmp[j-1] = t;
                        end
                    end
                    ch_n <= ch_n + 1;
                end
            end else begin
                for (int j = 0; j < DP - 1; j++) tmp[j] = tmp[j+1];
                tmp[DP-1] = '1;
                if (ch_n > 0) ch_n <= ch_n - 1;
            end
            ch <= tmp;
        end
    end
    assign arr_head = ch[0];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Output-ready pattern driver: mode 0 = always ready, mode 1 = 1,0,0,1 repeating.
    int ready_mode = 0;
    int rcyc = 0;
    always @(posedge clk) begin
        #1;
        rcyc++;
        if (ready_mode == 0) out_ready = 1'b1;
        else out_ready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
    end

    // Scoreboard and monitor.
    logic [DW:0]   exp_q[$];
    int            hs_count = 0;
    int            pop_count = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;
    logic          after_last = 1'b0;

    always @(negedge clk) begin
        logic [DW:0] e;
        if (rst) begin
            stall_prev = 1'b0;
            after_last = 1'b0;
        end else begin
            if (after_last) begin
                check("busy_after_last", {31'd0, busy}, 32'd0);
                check("in_ready_after_last", {31'd0, in_ready}, 32'd1);
                after_last = 1'b0;
            end
            if (stall_prev) begin
                check("stall_data_hold", {16'd0, out_data}, {16'd0, data_prev});
            end
            if (arr_clk_en && !arr_push) pop_count++;
            if (out_valid && !out_ready) begin
                check("stall_no_clk_en", {31'd0, arr_clk_en}, 32'd0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {16'd0, out_data}, {16'd0, e[DW-1:0]});
                    check("out_last", {31'd0, out_last}, {31'd0, e[DW]});
                end
                if (out_last) begin
                    check("in_ready_in_last_hs", {31'd0, in_ready}, 32'd0);
                    after_last = 1'b1;
                end
                hs_count++;
            end
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
        end
    end

    task automatic send_word(input logic [DW-1:0] d, input logic last);
        logic hs;
        int   n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        do begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 500);
        if (!hs) check("input_handshake_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_word(input logic [DW-1:0] d, input logic last);
        exp_q.push_back({last, d});
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check(name, 32'd0, 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_clk_en", {31'd0, arr_clk_en}, 32'd0);
        check("rst_push", {31'd0, arr_push}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // 1: 5,3,9,1 -> 1,3,5,9
        pop_count = 0;
        expect_word(16'd1, 1'b0); expect_word(16'd3, 1'b0);
        expect_word(16'd5, 1'b0); expect_word(16'd9, 1'b1);
        send_word(16'd5, 1'b0); send_word(16'd3, 1'b0);
        send_word(16'd9, 1'b0); send_word(16'd1, 1'b1);
        wait_done("t1_timeout");
        check("t1_pop_count", pop_count, 32'd4);

        // 2: full chain without last
        for (int i = 7; i >= 0; i--) expect_word(16'h00F0 + 16'(7 - i), (i == 0));
        for (int i = 7; i >= 0; i--) send_word(16'h00F0 + 16'(i), 1'b0);
        @(negedge clk);
        check("t2_settle_in_ready", {31'd0, in_ready}, 32'd0);
        check("t2_settle_clk_en", {31'd0, arr_clk_en}, 32'd0);
        check("t2_settle_busy", {31'd0, busy}, 32'd1);
        wait_done("t2_timeout");

        // 3: single word
        expect_word(16'hABCD, 1'b1);
        send_word(16'hABCD, 1'b1);
        wait_done("t3_timeout");

        // 4: stalled drain
        ready_mode = 1;
        expect_word(16'd2, 1'b0); expect_word(16'd2, 1'b0); expect_word(16'd7, 1'b1);
        send_word(16'd7, 1'b0); send_word(16'd2, 1'b0); send_word(16'd2, 1'b1);
        wait_done("t4_timeout");
        ready_mode = 0;

        // 5: reset in the middle of a drain
        hs_count = 0;
        for (int i = 1; i <= 6; i++) expect_word(16'(10 * i), (i == 6));
        for (int i = 6; i >= 1; i--) send_word(16'(10 * i), (i == 1));
        begin
            int n;
            n = 0;
            while (hs_count < 2 && n < 500) begin
                @(posedge clk);
                n++;
            end
            if (n >= 500) check("t5_drain_timeout", 32'd0, 32'd1);
        end
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t5_valid_after_rst", {31'd0, out_valid}, 32'd0);
        check("t5_busy_after_rst", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        expect_word(16'd0, 1'b0); expect_word(16'd4, 1'b1);
        send_word(16'd4, 1'b0); send_word(16'd0, 1'b1);
        wait_done("t5_timeout");

        // 6: back-to-back frames
        expect_word(16'd1, 1'b0); expect_word(16'd3, 1'b1);
        expect_word(16'd5, 1'b0); expect_word(16'd6, 1'b1);
        send_word(16'd3, 1'b0); send_word(16'd1, 1'b1);
        send_word(16'd6, 1'b0); send_word(16'd5, 1'b1);
        wait_done("t6_timeout");
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
